// File: rtl/multi_tc.sv
// multi_tc: a bank of NCH independent down-counting timer channels behind a
// word-addressed register port.
//
// Ports
//   clk      system clock; all state changes on the rising edge
//   reset    synchronous active-low reset (0 = reset)
//   Addr     word address [31:2]; Addr[3:2] register select, Addr[6:4] channel
//   WE       write enable for the addressed register
//   Din      write data
//   Dout     read data for the addressed register (combinational from Addr)
//   IRQ      per-channel interrupt request, PEND & IM, registered
//   IRQ_any  OR of all IRQ bits, registered
//
// Register map per channel
//   00 CTRL   [0] EN, [2:1] MODE (01 auto-reload, else one-shot), [3] IM, [7:4] PS
//   01 PRESET reload value, WIDTH bits
//   10 COUNT  current count, read-only
//   11 STATUS [0] PEND (write 1 to clear), [2:1] channel state
module multi_tc #(
   parameter int NCH   = 4,
   parameter int WIDTH = 32
) (
   input  logic           clk,
   input  logic           reset,
   input  logic [31:2]    Addr,
   input  logic           WE,
   input  logic [31:0]    Din,
   output logic [31:0]    Dout,
   output logic [NCH-1:0] IRQ,
   output logic           IRQ_any
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_LOAD = 2'b01,
      ST_CNT  = 2'b10,
      ST_INT  = 2'b11
   } state_t;

   localparam logic [1:0]       REG_CTRL    = 2'b00;
   localparam logic [1:0]       REG_PRESET  = 2'b01;
   localparam logic [1:0]       REG_COUNT   = 2'b10;
   localparam logic [1:0]       REG_STATUS  = 2'b11;
   localparam logic [1:0]       MODE_RELOAD = 2'b01;
   localparam logic [WIDTH-1:0] CNT_ONE     = WIDTH'(32'd1);

   logic [1:0]     regSel_s;
   logic [2:0]     chSel_s;
   logic [31:0]    rdData_s [NCH];
   logic [NCH-1:0] irqNext_s;
   logic [31:0]    dout_s;
   logic [NCH-1:0] irq_r;
   logic           irqAny_r;
   logic           unused_s;

   assign regSel_s = Addr[3:2];
   assign chSel_s  = Addr[6:4];
   // Upper address bits are not decoded; Din bits above WIDTH only matter for CTRL/STATUS
   assign unused_s = ^{Addr[31:7], Din};

   // Read mux: each channel's read word gated by its select; unpopulated channels give 0
   always_comb begin
      dout_s = 32'd0;
      for (int k = 0; k < NCH; k++) begin
         dout_s = dout_s | (rdData_s[k] & {32{chSel_s == 3'(k)}});
      end
   end

   assign Dout    = dout_s;
   assign IRQ     = irq_r;
   assign IRQ_any = irqAny_r;

   // Interrupt outputs registered from the PEND/IM values each channel takes this edge
   always_ff @(posedge clk) begin
      if (!reset) begin
         irq_r    <= {NCH{1'b0}};
         irqAny_r <= 1'b0;
      end else begin
         irq_r    <= irqNext_s;
         irqAny_r <= |irqNext_s;
      end
   end

   for (genvar i = 0; i < NCH; i++) begin : gCh
      logic             en_r;
      logic             im_r;
      logic             pend_r;
      logic [1:0]       mode_r;
      logic [3:0]       ps_r;
      logic [WIDTH-1:0] preset_r;
      logic [WIDTH-1:0] count_r;
      logic [14:0]      psCnt_r;
      state_t           state_r;

      logic             wrCtrl_s;
      logic             wrPreset_s;
      logic             wrStatus_s;
      logic             enWr_s;
      logic             imNext_s;
      logic             pendNext_s;
      logic             tick_s;
      logic [14:0]      psMax_s;
      logic [31:0]      rd_s;

      // Write strobes and the CTRL/STATUS values this channel takes on the coming edge
      always_comb begin
         wrCtrl_s   = WE && (chSel_s == 3'(i)) && (regSel_s == REG_CTRL);
         wrPreset_s = WE && (chSel_s == 3'(i)) && (regSel_s == REG_PRESET);
         wrStatus_s = WE && (chSel_s == 3'(i)) && (regSel_s == REG_STATUS);
         if (wrCtrl_s) begin
            enWr_s   = Din[0];
            imNext_s = Din[3];
         end else begin
            enWr_s   = en_r;
            imNext_s = im_r;
         end
         // Leaving INT sets PEND, and that beats a write-1-to-clear on the same edge
         if (state_r == ST_INT) begin
            pendNext_s = 1'b1;
         end else if (wrStatus_s && Din[0]) begin
            pendNext_s = 1'b0;
         end else begin
            pendNext_s = pend_r;
         end
         psMax_s = (15'd1 << ps_r) - 15'd1;
         // >= keeps the prescaler from running away if PS shrinks mid-count
         tick_s  = (psCnt_r >= psMax_s);
      end

      // Read word for this channel
      always_comb begin
         case (regSel_s)
            REG_CTRL:   rd_s = {24'd0, ps_r, im_r, mode_r, en_r};
            REG_PRESET: rd_s = 32'(preset_r);
            REG_COUNT:  rd_s = 32'(count_r);
            REG_STATUS: rd_s = {29'd0, state_r, pend_r};
            default:    rd_s = 32'd0;
         endcase
      end

      assign rdData_s[i]  = rd_s;
      assign irqNext_s[i] = pendNext_s & imNext_s;

      // Channel registers and timer state machine
      always_ff @(posedge clk) begin
         if (!reset) begin
            en_r     <= 1'b0;
            im_r     <= 1'b0;
            pend_r   <= 1'b0;
            mode_r   <= 2'b00;
            ps_r     <= 4'd0;
            preset_r <= {WIDTH{1'b0}};
            count_r  <= {WIDTH{1'b0}};
            psCnt_r  <= 15'd0;
            state_r  <= ST_IDLE;
         end else begin
            en_r   <= enWr_s;
            im_r   <= imNext_s;
            pend_r <= pendNext_s;
            if (wrCtrl_s) begin
               mode_r <= Din[2:1];
               ps_r   <= Din[7:4];
            end
            if (wrPreset_s) begin
               preset_r <= Din[WIDTH-1:0];
            end
            case (state_r)
               // IDLE looks at the EN being written, so the load lands one edge after the enable write
               ST_IDLE: begin
                  if (enWr_s) begin
                     state_r <= ST_LOAD;
                  end
               end
               ST_LOAD: begin
                  if (!en_r) begin
                     state_r <= ST_IDLE;
                  end else begin
                     count_r <= preset_r;
                     psCnt_r <= 15'd0;
                     state_r <= ST_CNT;
                  end
               end
               ST_CNT: begin
                  if (!en_r) begin
                     state_r <= ST_IDLE;
                  end else if (tick_s) begin
                     psCnt_r <= 15'd0;
                     if (count_r > CNT_ONE) begin
                        count_r <= count_r - CNT_ONE;
                     end else begin
                        count_r <= {WIDTH{1'b0}};
                        state_r <= ST_INT;
                     end
                  end else begin
                     psCnt_r <= psCnt_r + 15'd1;
                  end
               end
               // The mode in force when INT was reached decides the exit; one-shot clears EN
               // even if EN=1 is written on this same edge
               ST_INT: begin
                  if (mode_r == MODE_RELOAD) begin
                     state_r <= ST_LOAD;
                  end else begin
                     en_r    <= 1'b0;
                     state_r <= ST_IDLE;
                  end
               end
               default: begin
                  state_r <= ST_IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_multi_tc.sv
// Self-checking bench for multi_tc: directed scenarios plus randomized
// single-channel runs checked against an arithmetic timeline model.
module tb_multi_tc;

   localparam int NCH   = 4;
   localparam int WIDTH = 32;
   localparam int R_CTRL   = 0;
   localparam int R_PRESET = 1;
   localparam int R_COUNT  = 2;
   localparam int R_STATUS = 3;

   logic           clk = 1'b0;
   logic           reset;
   logic [31:2]    Addr;
   logic           WE;
   logic [31:0]    Din;
   logic [31:0]    Dout;
   logic [NCH-1:0] IRQ;
   logic           IRQ_any;

   int checks = 0;
   int errors = 0;

   multi_tc #(.NCH(NCH), .WIDTH(WIDTH)) dut (
      .clk(clk), .reset(reset), .Addr(Addr), .WE(WE), .Din(Din),
      .Dout(Dout), .IRQ(IRQ), .IRQ_any(IRQ_any)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:2] addrOf(input int ch, input int r);
      return {25'd0, 3'(ch), 2'(r)};
   endfunction

   // advance past the next rising edge
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input int ch, input int r, input logic [31:0] d);
      Addr = addrOf(ch, r);
      Din  = d;
      WE   = 1'b1;
      cyc();
      WE   = 1'b0;
      Din  = 32'd0;
   endtask

   task automatic rd(input int ch, input int r, output logic [31:0] d);
      Addr = addrOf(ch, r);
      #1;
      d = Dout;
   endtask

   task automatic doReset(input logic weOn);
      reset = 1'b0;
      WE    = weOn;
      Addr  = addrOf(3, R_CTRL);
      Din   = 32'h0000_0009;
      cyc();
      reset = 1'b1;
      WE    = 1'b0;
      Din   = 32'd0;
   endtask

   // Timeline model. j = edges since the EN write. A period is one LOAD edge,
   // max(preset,1) ticks of 2^ps cycles in CNT, then one INT cycle; PEND is set
   // when INT is left (j = period). One-shot then stays IDLE with count 0.
   function automatic void expectAt(input int j, input int preset, input int ps, input bit reload,
                                    output int cnt, output int st, output bit pend);
      int p, l, per, q;
      p    = 1 << ps;
      l    = (preset < 1) ? 1 : preset;
      per  = l * p + 2;
      pend = (j >= per);
      if (j >= per && !reload) begin
         cnt = 0;
         st  = 0;
      end else begin
         q = j % per;
         if (q == 0) begin
            cnt = 0;
            st  = 1;
         end else if (q <= l * p) begin
            cnt = preset - (q - 1) / p;
            if (cnt < 0) cnt = 0;
            st = 2;
         end else begin
            cnt = 0;
            st  = 3;
         end
      end
   endfunction

   logic [31:0] d;
   int          cnt, st, preset, ch, span;
   bit          pend;
   logic [3:0]  ps;
   logic        im, reload;
   logic [3:0]  expIrq;

   initial begin
      reset = 1'b0;
      WE    = 1'b0;
      Addr  = '0;
      Din   = 32'd0;

      // Reset state: every register of every address reads 0
      doReset(1'b0);
      for (int c = 0; c < 6; c++) begin
         for (int r = 0; r < 4; r++) begin
            rd(c, r, d);
            check($sformatf("reset_ch%0d_r%0d", c, r), d, 32'd0);
         end
      end
      check("reset_irq", 32'(IRQ), 32'd0);
      check("reset_irq_any", 32'(IRQ_any), 32'd0);

      // Ch0 PRESET=5 one-shot IM PS=0: 5,4,3,2,1,0, IRQ from edge 7
      doReset(1'b0);
      wr(0, R_PRESET, 32'd5);
      wr(0, R_CTRL, 32'h9);
      for (int j = 1; j <= 8; j++) begin
         cyc();
         rd(0, R_COUNT, d);
         check($sformatf("os_count_j%0d", j), d, (j >= 6) ? 32'd0 : 32'(6 - j));
         check($sformatf("os_irq_j%0d", j), 32'(IRQ), (j >= 7) ? 32'd1 : 32'd0);
         check($sformatf("os_any_j%0d", j), 32'(IRQ_any), (j >= 7) ? 32'd1 : 32'd0);
      end
      rd(0, R_CTRL, d);
      check("os_ctrl_en_cleared", d, 32'h8);

      // Ch1 auto-reload PRESET=3: IRQ every 5 cycles, W1C clears until next expiry
      doReset(1'b0);
      wr(1, R_PRESET, 32'd3);
      wr(1, R_CTRL, 32'hB);
      for (int j = 1; j <= 5; j++) begin
         cyc();
         check($sformatf("ar_irq_j%0d", j), 32'(IRQ), (j >= 5) ? 32'h2 : 32'd0);
      end
      wr(1, R_STATUS, 32'h7);
      rd(1, R_STATUS, d);
      check("ar_w1c_status", d, 32'h4);
      check("ar_w1c_irq", 32'(IRQ), 32'd0);
      for (int j = 7; j <= 10; j++) begin
         cyc();
         check($sformatf("ar_irq2_j%0d", j), 32'(IRQ), (j >= 10) ? 32'h2 : 32'd0);
      end

      // Ch2 PRESET=2 PS=2: decrements 4 cycles apart, PEND at edge 10
      doReset(1'b0);
      wr(2, R_PRESET, 32'd2);
      wr(2, R_CTRL, 32'h29);
      for (int j = 1; j <= 10; j++) begin
         cyc();
         rd(2, R_COUNT, d);
         if (j == 4)  check("ps_count_j4", d, 32'd2);
         if (j == 5)  check("ps_count_j5", d, 32'd1);
         if (j == 8)  check("ps_count_j8", d, 32'd1);
         if (j == 9) begin
            rd(2, R_STATUS, d);
            check("ps_state_int_j9", d, 32'h6);
         end
         if (j == 10) check("ps_irq_j10", 32'(IRQ), 32'h4);
      end

      // Ch0 auto-reload PRESET=5, PRESET=100 written mid-count
      doReset(1'b0);
      wr(0, R_PRESET, 32'd5);
      wr(0, R_CTRL, 32'hB);
      cyc();
      wr(0, R_PRESET, 32'd100);
      rd(0, R_COUNT, d);
      check("pw_count_j2", d, 32'd4);
      cyc();
      rd(0, R_COUNT, d);
      check("pw_count_j3", d, 32'd3);
      for (int j = 4; j <= 9; j++) begin
         cyc();
         rd(0, R_COUNT, d);
         if (j == 7) check("pw_irq_j7", 32'(IRQ), 32'h1);
         if (j == 8) check("pw_reload_j8", d, 32'd100);
         if (j == 9) check("pw_count_j9", d, 32'd99);
      end

      // W1C on the INT exit edge: set wins; channel 5 is not populated
      doReset(1'b0);
      wr(3, R_PRESET, 32'd2);
      wr(3, R_CTRL, 32'h9);
      for (int j = 1; j <= 3; j++) cyc();
      wr(3, R_STATUS, 32'h1);
      rd(3, R_STATUS, d);
      check("w1c_race_status", d, 32'h1);
      check("w1c_race_irq", 32'(IRQ), 32'h8);
      wr(5, R_CTRL, 32'hFF);
      wr(5, R_PRESET, 32'd123);
      for (int r = 0; r < 4; r++) begin
         rd(5, r, d);
         check($sformatf("ch5_r%0d", r), d, 32'd0);
      end
      for (int c = 0; c < 3; c++) begin
         rd(c, R_CTRL, d);
         check($sformatf("ch5_no_alias_ch%0d", c), d, 32'd0);
      end
      rd(3, R_CTRL, d);
      check("ch3_ctrl_kept", d, 32'h8);

      // Reset with WE active while ch3 COUNT=7
      doReset(1'b0);
      wr(3, R_PRESET, 32'd20);
      wr(3, R_CTRL, 32'h9);
      for (int j = 1; j <= 14; j++) cyc();
      rd(3, R_COUNT, d);
      check("rst_pre_count", d, 32'd7);
      doReset(1'b1);
      for (int c = 0; c < NCH; c++) begin
         for (int r = 0; r < 4; r++) begin
            rd(c, r, d);
            check($sformatf("rst_mid_ch%0d_r%0d", c, r), d, 32'd0);
         end
      end
      check("rst_mid_irq", 32'(IRQ), 32'd0);
      cyc();
      rd(3, R_STATUS, d);
      check("rst_mid_idle_after", d, 32'd0);

      // Randomized single-channel runs against the timeline model
      for (int t = 0; t < 12; t++) begin
         ch     = $urandom_range(0, NCH - 1);
         preset = $urandom_range(0, 6);
         ps     = 4'($urandom_range(0, 2));
         reload = 1'($urandom_range(0, 1));
         im     = 1'($urandom_range(0, 1));
         doReset(1'b0);
         wr(ch, R_PRESET, 32'(preset));
         wr(ch, R_CTRL, {24'd0, ps, im, 1'b0, reload, 1'b1});
         span = ((preset < 1) ? 1 : preset) * (1 << ps) + 2;
         span = reload ? 2 * span + 1 : span + 2;
         for (int j = 0; j <= span; j++) begin
            if (j > 0) cyc();
            expectAt(j, preset, int'(ps), reload, cnt, st, pend);
            rd(ch, R_COUNT, d);
            check($sformatf("rnd%0d_count_j%0d", t, j), d, 32'(cnt));
            rd(ch, R_STATUS, d);
            check($sformatf("rnd%0d_status_j%0d", t, j), d, 32'(st * 2 + int'(pend)));
            expIrq     = 4'd0;
            expIrq[ch] = pend & im;
            check($sformatf("rnd%0d_irq_j%0d", t, j), 32'(IRQ), 32'(expIrq));
            check($sformatf("rnd%0d_any_j%0d", t, j), 32'(IRQ_any), 32'(pend & im));
         end
         rd(ch, R_CTRL, d);
         check($sformatf("rnd%0d_ctrl", t), d, {24'd0, ps, im, 1'b0, reload, reload});
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
